// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined data-processing ALU: opcodes, shift types,
// operation classes and NZCV bit positions.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [1:0] CLS_DP = 2'b00;
  localparam logic [1:0] CLS_BR = 2'b01;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN: flags only, no register write.
  function automatic logic isCompare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_barrel_shifter.sv
// Combinational barrel shifter with shifter carry-out; scValid=0 means the
// caller should keep the existing C flag.
module alu_barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       shType,
  input  logic [SAW-1:0]   shAmt,
  output logic [WIDTH-1:0] result,
  output logic             sc,
  output logic             scValid
);

  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0] rotAmt;
  logic [IW-1:0] negAmt;
  logic [IW-1:0] lowIdx;
  logic          big;
  logic          exact;

  // WIDTH is a power of two, so the low bits are the amount modulo WIDTH and
  // the top bit flags an amount of WIDTH or more.
  always_comb begin
    rotAmt = shAmt[IW-1:0];
    negAmt = IW'(0) - rotAmt;
    lowIdx = rotAmt - IW'(1);
    big    = shAmt[SAW-1];
    exact  = (shAmt == SAW'(WIDTH));
  end

  always_comb begin
    result  = value;
    sc      = 1'b0;
    scValid = 1'b0;
    if (shAmt != '0) begin
      scValid = 1'b1;
      case (shType)
        SH_LSL: begin
          if (!big) begin
            result = value << rotAmt;
            sc     = value[negAmt];
          end else begin
            result = '0;
            sc     = exact ? value[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (!big) begin
            result = value >> rotAmt;
            sc     = value[lowIdx];
          end else begin
            result = '0;
            sc     = exact ? value[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (!big) begin
            result = $signed(value) >>> rotAmt;
            sc     = value[lowIdx];
          end else begin
            result = {WIDTH{value[WIDTH-1]}};
            sc     = value[WIDTH-1];
          end
        end
        default: begin
          // A zero rotate amount wraps lowIdx to WIDTH-1, giving the MSB carry.
          result = (value >> rotAmt) | (value << negAmt);
          sc     = value[lowIdx];
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_dp_pipe.sv
// Two-stage data-processing ALU: S1 registers the shifted operand, S2 evaluates
// the operation, holds the result and owns the NZCV register.
module alu_dp_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAW   = $clog2(WIDTH) + 1,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [3:0]       in_op,
  input  logic             in_s,
  input  logic [1:0]       in_sh_type,
  input  logic [SAW-1:0]   in_sh_amt,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wr,
  output logic [3:0]       out_flags,
  output logic             out_flags_we,
  output logic             out_err,
  output logic [TAGW-1:0]  out_tag,
  input  logic             flags_ld,
  input  logic [3:0]       flags_ld_val
);

  // Handshake: a transfer happens on a rising edge where valid && ready. A
  // producer holds valid and its payload until that edge; out_* stay stable
  // while out_valid && !out_ready. Each stage advances when it is empty or
  // the stage after it advances, so in_ready is combinational from out_ready.
  logic adv1, adv2;
  logic s1Valid, s2Valid;

  logic [1:0]       s1Class;
  logic [3:0]       s1Op;
  logic             s1S;
  logic [WIDTH-1:0] s1A;
  logic [23:0]      s1Off;
  logic [WIDTH-1:0] s1Shifted;
  logic             s1Sc, s1ScValid;
  logic [TAGW-1:0]  s1Tag;
  logic [3:0]       flagReg;

  logic [WIDTH-1:0] shValue;
  logic             shSc, shScValid;

  assign adv2      = !s2Valid || out_ready;
  assign adv1      = !s1Valid || adv2;
  assign in_ready  = adv1 && !reset;
  assign out_valid = s2Valid;

  alu_barrel_shifter #(.WIDTH(WIDTH), .SAW(SAW)) uShifter (
    .value   (in_b),
    .shType  (in_sh_type),
    .shAmt   (in_sh_amt),
    .result  (shValue),
    .sc      (shSc),
    .scValid (shScValid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid   <= 1'b0;
      s1Class   <= '0;
      s1Op      <= '0;
      s1S       <= 1'b0;
      s1A       <= '0;
      s1Off     <= '0;
      s1Shifted <= '0;
      s1Sc      <= 1'b0;
      s1ScValid <= 1'b0;
      s1Tag     <= '0;
    end else if (adv1) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Class   <= in_class;
        s1Op      <= in_op;
        s1S       <= in_s;
        s1A       <= in_a;
        s1Off     <= 24'(in_b);
        s1Shifted <= shValue;
        s1Sc      <= shSc;
        s1ScValid <= shScValid;
        s1Tag     <= in_tag;
      end
    end
  end

  logic [WIDTH-1:0] aluX, aluY, aluRes, brOff;
  logic [WIDTH:0]   aluSum;
  logic             aluCin, isArith, cNext, vNext;
  logic [3:0]       newFlags;
  logic [WIDTH-1:0] nextResult;
  logic             nextWr, nextWe, nextErr;

  // Subtractions are folded into x + ~y + cin so one adder yields the
  // architectural carry (NOT borrow) for every arithmetic opcode.
  always_comb begin
    aluX    = s1A;
    aluY    = s1Shifted;
    aluCin  = 1'b0;
    isArith = 1'b0;
    aluRes  = '0;
    case (s1Op)
      OP_AND, OP_TST: aluRes = s1A & s1Shifted;
      OP_EOR, OP_TEQ: aluRes = s1A ^ s1Shifted;
      OP_ORR:         aluRes = s1A | s1Shifted;
      OP_MOV:         aluRes = s1Shifted;
      OP_BIC:         aluRes = s1A & ~s1Shifted;
      OP_MVN:         aluRes = ~s1Shifted;
      OP_SUB, OP_CMP: begin isArith = 1'b1; aluY = ~s1Shifted; aluCin = 1'b1; end
      OP_RSB:         begin isArith = 1'b1; aluX = s1Shifted; aluY = ~s1A; aluCin = 1'b1; end
      OP_ADD, OP_CMN: isArith = 1'b1;
      OP_ADC:         begin isArith = 1'b1; aluCin = flagReg[FLAG_C]; end
      OP_SBC:         begin isArith = 1'b1; aluY = ~s1Shifted; aluCin = flagReg[FLAG_C]; end
      default:        begin isArith = 1'b1; aluX = s1Shifted; aluY = ~s1A; aluCin = flagReg[FLAG_C]; end
    endcase
    aluSum = {1'b0, aluX} + {1'b0, aluY} + {{WIDTH{1'b0}}, aluCin};
    cNext  = s1ScValid ? s1Sc : flagReg[FLAG_C];
    vNext  = flagReg[FLAG_V];
    if (isArith) begin
      aluRes = aluSum[WIDTH-1:0];
      cNext  = aluSum[WIDTH];
      vNext  = (aluX[WIDTH-1] == aluY[WIDTH-1]) && (aluRes[WIDTH-1] != aluX[WIDTH-1]);
    end
    newFlags         = '0;
    newFlags[FLAG_N] = aluRes[WIDTH-1];
    newFlags[FLAG_Z] = (aluRes == '0);
    newFlags[FLAG_C] = cNext;
    newFlags[FLAG_V] = vNext;
  end

  // Branch offset: sign-extended 24-bit word offset scaled to bytes.
  always_comb begin
    brOff = '0;
    for (int i = 2; i < WIDTH; i++) brOff[i] = s1Off[(i < 26) ? (i - 2) : 23];
  end

  always_comb begin
    nextResult = '0;
    nextWr     = 1'b0;
    nextWe     = 1'b0;
    nextErr    = 1'b0;
    case (s1Class)
      CLS_DP: begin
        nextResult = aluRes;
        nextWr     = !isCompare(s1Op);
        nextWe     = isCompare(s1Op) || s1S;
      end
      CLS_BR: begin
        nextResult = s1A + brOff;
        nextWr     = 1'b1;
      end
      default: nextErr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid      <= 1'b0;
      out_result   <= '0;
      out_wr       <= 1'b0;
      out_flags    <= '0;
      out_flags_we <= 1'b0;
      out_err      <= 1'b0;
      out_tag      <= '0;
      flagReg      <= '0;
    end else begin
      if (adv2) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          out_result   <= nextResult;
          out_wr       <= nextWr;
          out_flags    <= nextWe ? newFlags : flagReg;
          out_flags_we <= nextWe;
          out_err      <= nextErr;
          out_tag      <= s1Tag;
          if (nextWe) flagReg <= newFlags;
        end
      end
      // An external load on the same edge overrides the ALU update.
      if (flags_ld) flagReg <= flags_ld_val;
    end
  end

endmodule

// File: tb/tb_alu_dp_pipe.sv
// Randomised and directed bench for alu_dp_pipe with a scoreboard fed by an
// arithmetic reference model of the instruction semantics.
module tb_alu_dp_pipe;

  localparam int W    = 32;
  localparam int SAW  = 6;
  localparam int TAGW = 5;
  localparam int EW   = W + 1 + 4 + 1 + 1 + TAGW;

  logic            clk;
  logic            reset;
  logic            in_valid, in_ready;
  logic [1:0]      in_class;
  logic [3:0]      in_op;
  logic            in_s;
  logic [1:0]      in_sh_type;
  logic [SAW-1:0]  in_sh_amt;
  logic [W-1:0]    in_a, in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, out_ready;
  logic [W-1:0]    out_result;
  logic            out_wr;
  logic [3:0]      out_flags;
  logic            out_flags_we, out_err;
  logic [TAGW-1:0] out_tag;
  logic            flags_ld;
  logic [3:0]      flags_ld_val;

  alu_dp_pipe #(.WIDTH(W), .SAW(SAW), .TAGW(TAGW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_class     (in_class),
    .in_op        (in_op),
    .in_s         (in_s),
    .in_sh_type   (in_sh_type),
    .in_sh_amt    (in_sh_amt),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_wr       (out_wr),
    .out_flags    (out_flags),
    .out_flags_we (out_flags_we),
    .out_err      (out_err),
    .out_tag      (out_tag),
    .flags_ld     (flags_ld),
    .flags_ld_val (flags_ld_val)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_flags;
  int            n_cmp    = 0;
  int            n_fail   = 0;
  int            accepted = 0;
  bit            rand_on  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: operand shift by wide-vector arithmetic, ALU by integer math.
  task automatic model_op(input logic [1:0] cls, input logic [3:0] op, input logic s,
                          input logic [1:0] sht, input logic [5:0] amt,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic [95:0] wide;
    logic [31:0] sv, res, sext;
    logic        sc, scv, c, v, wr, we, err, arith;
    logic [3:0]  f;
    longint      ua, ub, sa, sb, sr, cin, brw;
    f = m_flags; res = '0; wr = 0; we = 0; err = 0;
    if (cls == 2'b01) begin
      sext = {{8{b[23]}}, b[23:0]};
      res  = a + (sext << 2);
      wr   = 1;
    end else if (cls[1]) begin
      err = 1;
    end else begin
      sv = b; sc = 0; scv = 0;
      if (amt != 0) begin
        scv = 1;
        case (sht)
          2'd0: begin wide = {64'd0, b} << amt; sv = wide[31:0]; sc = wide[32]; end
          2'd1: begin wide = {32'd0, b, 32'd0} >> amt; sv = wide[63:32]; sc = wide[31]; end
          2'd2: begin
            wide = {{32{b[31]}}, b, 32'd0};
            wide = $signed(wide) >>> amt;
            sv = wide[63:32]; sc = wide[31];
          end
          default: begin
            for (int i = 0; i < int'(amt); i++) sv = {sv[0], sv[31:1]};
            sc = sv[31];
          end
        endcase
      end
      ua = longint'(a); ub = longint'(sv);
      sa = longint'($signed(a)); sb = longint'($signed(sv));
      cin = longint'(m_flags[1]); brw = 1 - cin;
      c = m_flags[1]; v = m_flags[0]; arith = 1; sr = 0;
      case (op)
        4'h0, 4'h8: begin arith = 0; res = a & sv; end
        4'h1, 4'h9: begin arith = 0; res = a ^ sv; end
        4'hC:       begin arith = 0; res = a | sv; end
        4'hD:       begin arith = 0; res = sv; end
        4'hE:       begin arith = 0; res = a & ~sv; end
        4'hF:       begin arith = 0; res = ~sv; end
        4'h2, 4'hA: begin sr = sa - sb; c = (ua >= ub); res = 32'(ua - ub); end
        4'h3:       begin sr = sb - sa; c = (ub >= ua); res = 32'(ub - ua); end
        4'h4, 4'hB: begin sr = sa + sb; c = (ua + ub) > 64'hFFFF_FFFF; res = 32'(ua + ub); end
        4'h5:       begin sr = sa + sb + cin; c = (ua + ub + cin) > 64'hFFFF_FFFF; res = 32'(ua + ub + cin); end
        4'h6:       begin sr = sa - sb - brw; c = (ua >= ub + brw); res = 32'(ua - ub - brw); end
        default:    begin sr = sb - sa - brw; c = (ub >= ua + brw); res = 32'(ub - ua - brw); end
      endcase
      if (arith) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      else if (scv) c = sc;
      we = (op inside {[4'h8:4'hB]}) || s;
      wr = !(op inside {[4'h8:4'hB]});
      if (we) begin
        f = {res[31], res == 0, c, v};
        m_flags = f;
      end
    end
    exp_q.push_back({res, wr, f, we, err, tag});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [1:0] cls, input logic [3:0] op, input logic s,
                         input logic [1:0] sht, input logic [5:0] amt,
                         input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    logic [4:0] tag = 5'($urandom_range(0, 31));
    in_class = cls; in_op = op; in_s = s; in_sh_type = sht; in_sh_amt = amt;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
      in_valid = 0;
      return;
    end
    model_op(cls, op, s, sht, amt, a, b, tag);
    accepted++;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic load_flags(input logic [3:0] val);
    flags_ld = 1; flags_ld_val = val;
    @(posedge clk); #1;
    flags_ld = 0;
    m_flags = val;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got result %0h tag %0h expected no output", out_result, out_tag);
      end else begin
        check("out_pkt", 64'({out_result, out_wr, out_flags, out_flags_we, out_err, out_tag}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] edge_amt[8];
    int a0;
    edge_amt = '{6'd0, 6'd1, 6'd31, 6'd32, 6'd33, 6'd63, 6'd40, 6'd16};
    reset = 1; in_valid = 0; in_class = 0; in_op = 0; in_s = 0; in_sh_type = 0;
    in_sh_amt = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1;
    flags_ld = 0; flags_ld_val = 0; m_flags = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_pkt", 64'({out_result, out_wr, out_flags, out_flags_we, out_err, out_tag}), 64'd0);
    @(posedge clk); #1;
    reset = 0;

    // ADD overflow into sign bit, with latency observation
    send_op(2'b00, 4'h4, 1, 2'd0, 6'd0, 32'h7FFF_FFFF, 32'h1);
    check("latency_first_edge", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_second_edge", 64'(out_valid), 64'd1);
    drain();

    // Carry chain: ADDS then immediate ADC
    load_flags(4'b0000);
    send_op(2'b00, 4'h4, 1, 2'd0, 6'd0, 32'hFFFF_FFFF, 32'h1);
    send_op(2'b00, 4'h5, 0, 2'd0, 6'd0, 32'h2, 32'h3);
    drain();

    // Shifter boundaries through MOVS
    send_op(2'b00, 4'hD, 1, 2'd1, 6'd32, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd2, 6'd40, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd3, 6'd32, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd0, 6'd0, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd0, 6'd32, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd0, 6'd33, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd1, 6'd33, 0, 32'h8000_0001);
    send_op(2'b00, 4'hD, 1, 2'd3, 6'd36, 0, 32'h8000_0001);
    send_op(2'b00, 4'hA, 0, 2'd0, 6'd0, 32'h5, 32'h5);
    drain();

    // External flag load on the edge an ADDS enters S2
    send_op(2'b00, 4'h4, 1, 2'd0, 6'd0, 32'hFFFF_FFFF, 32'h1);
    load_flags(4'b1001);
    send_op(2'b00, 4'h5, 1, 2'd0, 6'd0, 32'h0, 32'h0);
    drain();

    // Branch and illegal class
    send_op(2'b01, 4'h0, 0, 2'd0, 6'd0, 32'h100, 32'h00FF_FFFE);
    send_op(2'b01, 4'h0, 1, 2'd0, 6'd0, 32'h1000, 32'hAB00_0010);
    send_op(2'b10, 4'h4, 1, 2'd0, 6'd0, 32'h1, 32'h1);
    send_op(2'b11, 4'hA, 0, 2'd0, 6'd0, 32'h1, 32'h1);
    drain();

    // Backpressure: four ops with writeback stalled for three cycles
    out_ready = 0;
    a0 = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_op(2'b00, 4'(2 + i), 1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)),
                  $urandom, $urandom);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_accepted_two", 64'(accepted - a0), 64'd2);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();

    // Random traffic with random writeback stalls
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          int k = $urandom_range(0, 9);
          logic [1:0] cls = (k < 7) ? 2'b00 : (k < 9) ? 2'b01 : 2'($urandom_range(2, 3));
          logic [5:0] amt = ($urandom_range(0, 1) != 0) ? edge_amt[$urandom_range(0, 7)]
                                                        : 6'($urandom_range(0, 63));
          send_op(cls, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), amt, $urandom, $urandom);
        end
        rand_on = 0;
      end
    join
    drain();

    // Reset in the middle of a stalled stream
    load_flags(4'b1111);
    out_ready = 0;
    send_op(2'b00, 4'h4, 1, 2'd0, 6'd0, 32'h10, 32'h20);
    send_op(2'b00, 4'h4, 1, 2'd0, 6'd0, 32'h30, 32'h40);
    reset = 1;
    exp_q.delete();
    m_flags = 4'b0000;
    @(negedge clk);
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_pkt", 64'({out_result, out_wr, out_flags, out_flags_we, out_err, out_tag}), 64'd0);
    reset = 0;
    out_ready = 1;
    send_op(2'b00, 4'h5, 1, 2'd0, 6'd0, 32'h0, 32'h0);
    send_op(2'b00, 4'h6, 1, 2'd0, 6'd0, 32'h9, 32'h4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
